// File: rtl/ps2_writer.sv
// rtl/ps2_writer.sv - PS/2 host-to-device byte transmitter with inhibit/RTS, ack check and timeout
module ps2_writer #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_START, S_XFER, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic          clk_meta_q, clk_sync_q, clk_last_q;
  logic          data_meta_q, data_sync_q;
  logic [7:0]    byte_q;
  logic          parity_q;
  logic [3:0]    bit_cnt_q;
  logic [3:0]    bit_cnt_d;
  logic [CW-1:0] cnt_q;
  logic          clk_oe_q, data_oe_q, busy_q, done_q, error_q;
  logic [1:0]    err_code_q;
  logic          fe;
  logic          timed;

  // Synchronizers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_last_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_last_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fe        = clk_last_q & ~clk_sync_q;
  assign bit_cnt_d = bit_cnt_q + 4'd1;
  assign timed     = (state_q == S_START) || (state_q == S_XFER) ||
                     (state_q == S_ACK)   || (state_q == S_WAIT_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (timed && !fe && (cnt_q == TO_LAST)) begin
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        busy_q     <= 1'b0;
        error_q    <= 1'b1;
        err_code_q <= 2'b10;
        state_q    <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            // done_q/error_q high means we just came back here; that start is dropped.
            if (start && !done_q && !error_q) begin
              byte_q     <= tx_byte;
              parity_q   <= ~^tx_byte;
              err_code_q <= 2'b00;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
              bit_cnt_q  <= '0;
              clk_oe_q   <= 1'b1;
              state_q    <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
              data_oe_q <= 1'b1;
              state_q   <= S_RTS;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_RTS: begin
            clk_oe_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_START;
          end
          S_START, S_XFER: begin
            cnt_q <= fe ? '0 : cnt_q + 1'b1;
            if (fe) begin
              bit_cnt_q <= bit_cnt_d;
              state_q   <= S_XFER;
              if (bit_cnt_d <= 4'd8) begin
                data_oe_q <= ~byte_q[bit_cnt_q[2:0]];
              end else if (bit_cnt_d == 4'd9) begin
                data_oe_q <= ~parity_q;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= S_ACK;
              end
            end
          end
          S_ACK: begin
            cnt_q <= fe ? '0 : cnt_q + 1'b1;
            if (fe) begin
              if (!data_sync_q) begin
                state_q <= S_WAIT_IDLE;
              end else begin
                clk_oe_q   <= 1'b0;
                data_oe_q  <= 1'b0;
                busy_q     <= 1'b0;
                error_q    <= 1'b1;
                err_code_q <= 2'b01;
                state_q    <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            cnt_q <= fe ? '0 : cnt_q + 1'b1;
            if (clk_sync_q && data_sync_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule
